// File: rtl/guard_cfg_seq.sv
// Register-bus initiator for the AXI slave guard configuration port.
// Issues a configuration write burst, then services the guard irq.
module guard_cfg_seq #(
    parameter int RegAddrWidth  = 32,
    parameter int RegDataWidth  = 32,
    parameter int NumInitWrites = 4,
    parameter logic [RegAddrWidth-1:0] BaseAddr =
        RegAddrWidth'(32'h0),
    parameter logic [RegAddrWidth-1:0] StatusOffset =
        RegAddrWidth'(32'h10),
    parameter logic [RegAddrWidth-1:0] ClearOffset =
        RegAddrWidth'(32'h14),
    parameter int TimeoutCycles = 255,
    parameter int IrqHoldoff    = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic [NumInitWrites*RegAddrWidth-1:0] init_addr_i,
    input  logic [NumInitWrites*RegDataWidth-1:0] init_data_i,
    input  logic irq_i,
    output logic [RegAddrWidth-1:0] reg_req_addr_o,
    output logic reg_req_write_o,
    output logic [RegDataWidth-1:0] reg_req_wdata_o,
    output logic [RegDataWidth/8-1:0] reg_req_wstrb_o,
    output logic reg_req_valid_o,
    input  logic [RegDataWidth-1:0] reg_rsp_rdata_i,
    input  logic reg_rsp_error_i,
    input  logic reg_rsp_ready_i,
    output logic busy_o,
    output logic cfg_done_o,
    output logic [RegDataWidth-1:0] status_o,
    output logic status_valid_o,
    output logic err_o,
    output logic [1:0] err_code_o
);

    localparam int AW = RegAddrWidth;
    localparam int DW = RegDataWidth;
    localparam int SW = RegDataWidth / 8;

    localparam int IW = (NumInitWrites > 1) ?
        $clog2(NumInitWrites) : 1;
    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam int HW = (IrqHoldoff > 1) ?
        $clog2(IrqHoldoff) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(NumInitWrites - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TimeoutCycles - 1);
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((IrqHoldoff > 0) ? IrqHoldoff - 1 : 0);

    localparam logic [AW-1:0] STAT_ADDR = BaseAddr + StatusOffset;
    localparam logic [AW-1:0] CLR_ADDR = BaseAddr + ClearOffset;

    localparam logic [1:0] CODE_BUS = 2'd1;
    localparam logic [1:0] CODE_TO = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_WR,
        S_WAIT_IRQ,
        S_RD_STAT,
        S_WR_CLR,
        S_HOLD,
        S_ERR
    } state_t;

    state_t state;
    logic [IW-1:0] idx;
    logic [TW-1:0] tcnt;
    logic [HW-1:0] hcnt;

    logic [AW-1:0] init_addr [NumInitWrites];
    logic [DW-1:0] init_data [NumInitWrites];

    for (genvar k = 0; k < NumInitWrites; k++) begin : g_unpack
        assign init_addr[k] = init_addr_i[k*AW +: AW];
        assign init_data[k] = init_data_i[k*DW +: DW];
    end

    logic in_bus;
    logic done_xfer;
    logic stalled;

    assign in_bus = (state == S_INIT_WR) ||
                    (state == S_RD_STAT) ||
                    (state == S_WR_CLR);
    assign done_xfer = reg_req_valid_o && reg_rsp_ready_i;
    assign stalled = reg_req_valid_o && !reg_rsp_ready_i;

    assign busy_o = in_bus || (state == S_HOLD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            idx             <= '0;
            tcnt            <= '0;
            hcnt            <= '0;
            reg_req_addr_o  <= '0;
            reg_req_write_o <= 1'b0;
            reg_req_wdata_o <= '0;
            reg_req_wstrb_o <= '0;
            reg_req_valid_o <= 1'b0;
            cfg_done_o      <= 1'b0;
            status_o        <= '0;
            status_valid_o  <= 1'b0;
            err_o           <= 1'b0;
            err_code_o      <= 2'd0;
        end else begin
            status_valid_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state      <= S_INIT_WR;
                        idx        <= '0;
                        cfg_done_o <= 1'b0;
                    end
                end
                S_WAIT_IRQ: begin
                    if (start_i) begin
                        state      <= S_INIT_WR;
                        idx        <= '0;
                        cfg_done_o <= 1'b0;
                    end else if (irq_i) begin
                        state <= S_RD_STAT;
                    end
                end
                S_INIT_WR, S_RD_STAT, S_WR_CLR: begin
                    if (!reg_req_valid_o) begin
                        // idle gap done: launch this state's request
                        reg_req_valid_o <= 1'b1;
                        tcnt            <= '0;
                        unique case (1'b1)
                            state == S_INIT_WR: begin
                                reg_req_addr_o  <= init_addr[idx];
                                reg_req_write_o <= 1'b1;
                                reg_req_wdata_o <= init_data[idx];
                                reg_req_wstrb_o <= '1;
                            end
                            state == S_RD_STAT: begin
                                reg_req_addr_o  <= STAT_ADDR;
                                reg_req_write_o <= 1'b0;
                                reg_req_wdata_o <= '0;
                                reg_req_wstrb_o <= '0;
                            end
                            default: begin
                                reg_req_addr_o  <= CLR_ADDR;
                                reg_req_write_o <= 1'b1;
                                reg_req_wdata_o <= status_o;
                                reg_req_wstrb_o <= '1;
                            end
                        endcase
                    end else if (done_xfer) begin
                        reg_req_valid_o <= 1'b0;
                        tcnt            <= '0;
                        if (reg_rsp_error_i) begin
                            state      <= S_ERR;
                            err_o      <= 1'b1;
                            err_code_o <= CODE_BUS;
                        end else begin
                            unique case (1'b1)
                                state == S_INIT_WR: begin
                                    if (idx == IDX_LAST) begin
                                        cfg_done_o <= 1'b1;
                                        hcnt       <= '0;
                                        state      <= (IrqHoldoff > 0) ?
                                            S_HOLD : S_WAIT_IRQ;
                                    end else begin
                                        idx <= idx + 1'b1;
                                    end
                                end
                                state == S_RD_STAT: begin
                                    status_o       <= reg_rsp_rdata_i;
                                    status_valid_o <= 1'b1;
                                    state          <= S_WR_CLR;
                                end
                                default: begin
                                    hcnt  <= '0;
                                    state <= (IrqHoldoff > 0) ?
                                        S_HOLD : S_WAIT_IRQ;
                                end
                            endcase
                        end
                    end else if (stalled) begin
                        tcnt <= tcnt + 1'b1;
                        if (tcnt == TO_LAST) begin
                            // abandon the transfer
                            reg_req_valid_o <= 1'b0;
                            state           <= S_ERR;
                            err_o           <= 1'b1;
                            err_code_o      <= CODE_TO;
                        end
                    end
                end
                S_HOLD: begin
                    if (hcnt == HOLD_LAST) begin
                        hcnt  <= '0;
                        state <= S_WAIT_IRQ;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                S_ERR: begin
                    reg_req_valid_o <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guard_cfg_seq.sv
// Bench for guard_cfg_seq: spec-level phase model, regbus responder,
// per-cycle compare plus directed scenario checks.
module tb_guard_cfg_seq;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam int HO = 2;

    localparam int P_IDLE = 0;
    localparam int P_INIT = 1;
    localparam int P_WAIT = 2;
    localparam int P_RD   = 3;
    localparam int P_CLR  = 4;
    localparam int P_HOLD = 5;
    localparam int P_ERR  = 6;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic irq;
    logic [N*AW-1:0] init_addr;
    logic [N*DW-1:0] init_data;
    logic [AW-1:0] req_addr;
    logic req_write;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic req_valid;
    logic [DW-1:0] rsp_rdata;
    logic rsp_error;
    logic rsp_ready;
    logic busy;
    logic cfg_done;
    logic [DW-1:0] status;
    logic status_valid;
    logic err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    guard_cfg_seq #(
        .RegAddrWidth (AW),
        .RegDataWidth (DW),
        .NumInitWrites(N),
        .TimeoutCycles(TO),
        .IrqHoldoff   (HO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .init_addr_i    (init_addr),
        .init_data_i    (init_data),
        .irq_i          (irq),
        .reg_req_addr_o (req_addr),
        .reg_req_write_o(req_write),
        .reg_req_wdata_o(req_wdata),
        .reg_req_wstrb_o(req_wstrb),
        .reg_req_valid_o(req_valid),
        .reg_rsp_rdata_i(rsp_rdata),
        .reg_rsp_error_i(rsp_error),
        .reg_rsp_ready_i(rsp_ready),
        .busy_o         (busy),
        .cfg_done_o     (cfg_done),
        .status_o       (status),
        .status_valid_o (status_valid),
        .err_o          (err),
        .err_code_o     (err_code)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // model state
    int m_phase = P_IDLE;
    int m_idx = 0;
    int m_stall = 0;
    int m_hold = 0;
    logic m_cfg_done = 1'b0;
    logic m_err = 1'b0;
    logic [1:0] m_code = 2'd0;
    logic [DW-1:0] m_status = '0;
    logic m_sv = 1'b0;
    bit m_last_cmpl = 0;
    bit m_keep_valid = 0;

    // inputs/outputs seen during the previous cycle
    bit s_have = 0;
    logic s_rst, s_start, s_irq, s_valid, s_ready, s_error;
    logic s_write;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_rdata, s_wdata;
    logic [SW-1:0] s_strb;

    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];
    logic log_write [$];
    logic [SW-1:0] log_strb [$];

    int rsp_lat = 1;
    int rsp_err_txn = -1;
    bit rsp_stall = 0;
    logic [DW-1:0] rsp_val = '0;
    int txn_cnt = 0;
    int vcnt = 0;
    int last_run = 0;
    int sv_pulses = 0;

    task automatic enter_hold();
        m_hold = HO;
        m_phase = P_HOLD;
    endtask

    task automatic model_step();
        m_sv = 1'b0;
        m_last_cmpl = 0;
        m_keep_valid = 0;
        if (s_rst) begin
            m_phase = P_IDLE;
            m_idx = 0;
            m_stall = 0;
            m_hold = 0;
            m_cfg_done = 1'b0;
            m_err = 1'b0;
            m_code = 2'd0;
            m_status = '0;
        end else begin
            case (m_phase)
                P_IDLE, P_WAIT: begin
                    if (s_start) begin
                        m_phase = P_INIT;
                        m_idx = 0;
                        m_cfg_done = 1'b0;
                    end else if (s_irq && m_phase == P_WAIT) begin
                        m_phase = P_RD;
                    end
                end
                P_HOLD: begin
                    m_hold--;
                    if (m_hold == 0) m_phase = P_WAIT;
                end
                P_INIT, P_RD, P_CLR: begin
                    if (s_valid && s_ready) begin
                        m_stall = 0;
                        m_last_cmpl = 1;
                        txn_cnt++;
                        log_addr.push_back(s_addr);
                        log_data.push_back(s_wdata);
                        log_write.push_back(s_write);
                        log_strb.push_back(s_strb);
                        if (s_error) begin
                            m_phase = P_ERR;
                            m_err = 1'b1;
                            m_code = 2'd1;
                        end else if (m_phase == P_INIT) begin
                            if (m_idx == N - 1) begin
                                m_cfg_done = 1'b1;
                                enter_hold();
                            end else begin
                                m_idx++;
                            end
                        end else if (m_phase == P_RD) begin
                            m_status = s_rdata;
                            m_sv = 1'b1;
                            m_phase = P_CLR;
                        end else begin
                            enter_hold();
                        end
                    end else if (s_valid) begin
                        m_stall++;
                        if (m_stall == TO) begin
                            m_phase = P_ERR;
                            m_err = 1'b1;
                            m_code = 2'd2;
                        end else begin
                            m_keep_valid = 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        logic ew;
        bit bus;
        bus = 1;
        ea = '0;
        ed = '0;
        es = '0;
        ew = 1'b0;
        case (m_phase)
            P_INIT: begin
                ea = init_addr[m_idx*AW +: AW];
                ed = init_data[m_idx*DW +: DW];
                es = '1;
                ew = 1'b1;
            end
            P_RD: begin
                ea = 32'h10;
            end
            P_CLR: begin
                ea = 32'h14;
                ed = m_status;
                es = '1;
                ew = 1'b1;
            end
            default: bus = 0;
        endcase
        if (req_valid) begin
            if (bus) begin
                chk("req_addr", req_addr, ea);
                chk("req_write", req_write, ew);
                chk("req_wdata", req_wdata, ed);
                chk("req_wstrb", req_wstrb, es);
            end else begin
                chk("valid_outside_bus", req_valid, 0);
            end
        end
        if (m_last_cmpl) chk("valid_gap", req_valid, 0);
        if (m_keep_valid) chk("valid_hold", req_valid, 1);
        chk("busy", busy, (m_phase == P_INIT || m_phase == P_RD ||
                           m_phase == P_CLR || m_phase == P_HOLD));
        chk("cfg_done", cfg_done, m_cfg_done);
        chk("err", err, m_err);
        chk("err_code", err_code, m_code);
        chk("status", status, m_status);
        chk("status_valid", status_valid, m_sv);
        if (status_valid) sv_pulses++;
    endtask

    // model step, compare, responder, snapshot on every falling edge
    initial begin
        rsp_ready = 1'b0;
        rsp_error = 1'b0;
        rsp_rdata = '0;
        forever begin
            @(negedge clk);
            if (s_have) begin
                model_step();
                compare();
            end
            if (req_valid) begin
                if (!rsp_stall && vcnt >= rsp_lat) begin
                    rsp_ready = 1'b1;
                    rsp_error = (txn_cnt == rsp_err_txn);
                    rsp_rdata = rsp_val;
                end else begin
                    rsp_ready = 1'b0;
                    rsp_error = 1'b1;
                    rsp_rdata = $urandom;
                end
                vcnt++;
            end else begin
                if (vcnt > 0) last_run = vcnt;
                vcnt = 0;
                rsp_ready = 1'b0;
                rsp_error = 1'b0;
                rsp_rdata = $urandom;
            end
            s_rst = rst;
            s_start = start;
            s_irq = irq;
            s_valid = req_valid;
            s_ready = rsp_ready;
            s_error = rsp_error;
            s_rdata = rsp_rdata;
            s_addr = req_addr;
            s_wdata = req_wdata;
            s_write = req_write;
            s_strb = req_wstrb;
            s_have = 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input int budget,
                              input string name);
        int k;
        k = 0;
        tick(2);
        while (m_phase != ph && k < budget) begin
            tick(1);
            k++;
        end
        chk({name, "_reached"}, (m_phase == ph), 1);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_write.delete();
        log_strb.delete();
        txn_cnt = 0;
    endtask

    task automatic set_init(input logic [AW-1:0] a0,
                            input logic [AW-1:0] astep,
                            input logic [DW-1:0] d0);
        for (int i = 0; i < N; i++) begin
            init_addr[i*AW +: AW] = a0 + astep * i;
            init_data[i*DW +: DW] = d0 + i;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        irq = 1'b0;
        set_init(32'h0, 32'h4, 32'hA0);
        tick(3);
        rst = 1'b0;
        chk("rst_valid", req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_err", err, 0);
        chk("rst_status", status, 0);

        // basic init burst
        clear_log();
        rsp_lat = 1;
        pulse_start();
        wait_phase(P_WAIT, 100, "init");
        chk("init_count", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("init_addr", log_addr[i], 64'(i * 4));
                chk("init_data", log_data[i], 64'(32'hA0 + i));
                chk("init_strb", log_strb[i], 4'hF);
                chk("init_write", log_write[i], 1);
            end
        end
        chk("init_cfg_done", cfg_done, 1);
        chk("init_busy", busy, 0);

        // interrupt service, irq raised again inside holdoff
        clear_log();
        sv_pulses = 0;
        rsp_lat = 0;
        rsp_val = 32'h5;
        irq = 1'b1;
        tick(1);
        irq = 1'b0;
        wait_phase(P_HOLD, 50, "irq_hold");
        irq = 1'b1;
        tick(1);
        irq = 1'b0;
        tick(5);
        chk("irq_phase", m_phase, P_WAIT);
        chk("irq_count", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("irq_rd_addr", log_addr[0], 32'h10);
            chk("irq_rd_write", log_write[0], 0);
            chk("irq_clr_addr", log_addr[1], 32'h14);
            chk("irq_clr_data", log_data[1], 32'h5);
            chk("irq_clr_write", log_write[1], 1);
        end
        chk("irq_status", status, 32'h5);
        chk("irq_sv_pulses", sv_pulses, 1);
        chk("irq_busy", busy, 0);

        // start and irq together: restart init, no status read
        clear_log();
        set_init(32'h100, 32'h4, 32'hB0);
        rsp_lat = 2;
        start = 1'b1;
        irq = 1'b1;
        tick(1);
        start = 1'b0;
        irq = 1'b0;
        wait_phase(P_WAIT, 150, "prio");
        chk("prio_count", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            chk("prio_first_addr", log_addr[0], 32'h100);
            chk("prio_first_data", log_data[0], 32'hB0);
            chk("prio_last_addr", log_addr[3], 32'h10C);
            for (int i = 0; i < 4; i++)
                chk("prio_all_writes", log_write[i], 1);
        end
        chk("prio_cfg_done", cfg_done, 1);

        // bus error on the second init write
        clear_log();
        rsp_lat = 1;
        rsp_err_txn = 1;
        pulse_start();
        wait_phase(P_ERR, 100, "buserr");
        tick(3);
        chk("buserr_count", log_addr.size(), 2);
        chk("buserr_err", err, 1);
        chk("buserr_code", err_code, 1);
        chk("buserr_cfg_done", cfg_done, 0);
        pulse_start();
        tick(10);
        chk("buserr_start_ign", log_addr.size(), 2);
        chk("buserr_valid", req_valid, 0);
        chk("buserr_busy", busy, 0);
        rsp_err_txn = -1;
        do_reset();
        chk("post_rst_err", err, 0);
        chk("post_rst_code", err_code, 0);

        // timeout with ready held low
        clear_log();
        rsp_stall = 1;
        pulse_start();
        wait_phase(P_ERR, 60, "timeout");
        tick(2);
        chk("to_run", last_run, 8);
        chk("to_code", err_code, 2);
        chk("to_err", err, 1);
        chk("to_valid", req_valid, 0);
        chk("to_count", log_addr.size(), 0);
        do_reset();

        // reset while a transfer is stalled
        clear_log();
        set_init(32'hFFFF_FFF0, 32'h4, 32'hC0);
        pulse_start();
        tick(4);
        chk("mid_valid", req_valid, 1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_valid", req_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", req_addr, 0);
        rst = 1'b0;
        rsp_stall = 0;
        rsp_lat = 7;
        tick(1);
        clear_log();
        pulse_start();
        wait_phase(P_WAIT, 200, "rerun");
        chk("rerun_count", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            chk("rerun_first", log_addr[0], 32'hFFFF_FFF0);
            chk("rerun_last", log_addr[3], 32'hFFFF_FFFC);
            chk("rerun_data", log_data[3], 32'hC3);
        end
        chk("rerun_run", last_run, 8);
        chk("rerun_err", err, 0);
        chk("rerun_cfg_done", cfg_done, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/guard_cfg_seq.md
Name: guard_cfg_seq

Overview:
Register-bus initiator that drives the configuration port of the AXI slave guard. On start it issues a fixed burst of configuration writes, then services the guard interrupt. Servicing means reading the status register and writing the value back to the write-1-to-clear register. It sits next to the guard in the subsystem and replaces a software driver for standalone or safety deployments.

Parameters:
RegAddrWidth, 32, regbus address width
RegDataWidth, 32, regbus data width (multiple of 8)
NumInitWrites, 4, number of configuration writes per start (>=1)
BaseAddr, 32'h0, guard register base address
StatusOffset, 32'h10, offset of the irq status register
ClearOffset, 32'h14, offset of the write-1-to-clear register
TimeoutCycles, 255, max cycles valid may stay high without ready (>=1)
IrqHoldoff, 2, cycles irq_i is ignored after a clear write completes

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start init sequence (level, sampled)
init_addr_i  in  NumInitWrites*RegAddrWidth  packed write addresses, entry 0 in LSBs
init_data_i  in  NumInitWrites*RegDataWidth  packed write data, entry 0 in LSBs
irq_i  in  1  guard interrupt (level)
reg_req_addr_o  out  RegAddrWidth  regbus address
reg_req_write_o  out  1  1=write, 0=read
reg_req_wdata_o  out  RegDataWidth  write data
reg_req_wstrb_o  out  RegDataWidth/8  byte strobes
reg_req_valid_o  out  1  request valid
reg_rsp_rdata_i  in  RegDataWidth  read data
reg_rsp_error_i  in  1  response error
reg_rsp_ready_i  in  1  request accepted/completed
busy_o  out  1  FSM not in IDLE/WAIT_IRQ/ERR
cfg_done_o  out  1  init sequence completed (sticky)
status_o  out  RegDataWidth  last status read
status_valid_o  out  1  one-cycle pulse when status_o updates
err_o  out  1  sticky error
err_code_o  out  2  0 none, 1 bus error, 2 timeout

Behaviour:
- Reset (rst_i high at an edge): state IDLE; all outputs 0; index, timeout and holdoff counters 0.
- Regbus rules:
  - A transfer completes in the cycle where valid and ready are both high.
  - addr, write, wdata and wstrb are registered and stay stable while valid is high.
  - valid drops in the cycle after completion; there are no back-to-back requests (min one idle cycle).
  - wstrb is all ones on writes and 0 on reads; wdata is 0 on reads.
  - reg_rsp_error_i and reg_rsp_rdata_i are sampled only in the completion cycle.
- States:
  - IDLE: start_i high -> INIT_WR with idx=0; cfg_done_o cleared.
  - INIT_WR: write init_addr[idx] / init_data[idx].
    - Completion with error -> ERR, code 1.
    - Completion, idx==NumInitWrites-1 -> HOLD; cfg_done_o=1 next cycle.
    - Otherwise idx++ and issue the next write.
  - WAIT_IRQ:
    - start_i -> INIT_WR, restart at idx 0, cfg_done_o cleared. start_i has priority over irq_i in the same cycle.
    - Otherwise irq_i -> RD_STAT.
  - RD_STAT: read BaseAddr+StatusOffset.
    - Completion with error -> ERR, code 1.
    - Otherwise capture rdata into status_o, pulse status_valid_o the next cycle, -> WR_CLR.
  - WR_CLR: write BaseAddr+ClearOffset with wdata=captured status.
    - Completion with error -> ERR, code 1.
    - Otherwise -> HOLD.
  - HOLD: count IrqHoldoff cycles, ignoring irq_i and start_i, then -> WAIT_IRQ.
  - ERR: valid 0, err_o=1, err_code_o held; exit only by reset.
- start_i is ignored in every state except IDLE and WAIT_IRQ.
- Timeout:
  - The counter increments each cycle with valid high and ready low, and clears on completion.
  - When it reaches TimeoutCycles -> ERR, code 2, valid deasserted the next cycle (the transfer is abandoned).
- Address arithmetic is modulo 2^RegAddrWidth.
- Width rule: entry k of the packed inputs is bits [k*W +: W].
- Mid-transfer reset: valid is 0 after the reset edge; there is no completion tracking across reset.

Test Plan:
- Basic init: NumInitWrites=4, addrs 0x0/0x4/0x8/0xC, data 0xA0..0xA3, ready after 1 cycle -> 4 writes in order, wstrb=0xF, cfg_done_o=1, busy_o=0 after.
- Interrupt service: irq_i high in WAIT_IRQ, rdata=0x5 -> read at 0x10, status_o=0x5 with 1-cycle status_valid_o, write 0x5 to 0x14, irq_i ignored for 2 cycles, back in WAIT_IRQ.
- Bus error: error_i=1 on the 2nd init write -> no 3rd write, err_o=1, err_code_o=1, start_i ignored until reset.
- Timeout: ready held low with TimeoutCycles=8 -> valid drops after 8 stalled cycles, err_code_o=2.
- Priority/restart: start_i and irq_i rise together in WAIT_IRQ -> init sequence restarts at entry 0, no status read.
- Reset mid-transfer: rst_i asserted while valid high and ready low -> all outputs 0 next cycle; a new start_i reruns init from entry 0.
